// File: rtl/ni_inject_if.sv
// Injection-side bundle: send request, payload stream, flit output and credit return.
interface ni_inject_if #(
  parameter int DATAW = 32,
  parameter int XW    = 4,
  parameter int YW    = 4,
  parameter int NVCH  = 2,
  parameter int LENW  = 4
);
  localparam int VCW = (NVCH > 1) ? $clog2(NVCH) : 1;

  logic             req_valid;
  logic             req_ready;
  logic [XW-1:0]    req_dst_x;
  logic [YW-1:0]    req_dst_y;
  logic [VCW-1:0]   req_vch;
  logic [LENW-1:0]  req_len;

  logic             pl_valid;
  logic             pl_ready;
  logic [DATAW-1:0] pl_data;

  logic             flit_valid;
  logic [1:0]       flit_type;
  logic [VCW-1:0]   flit_vch;
  logic [DATAW-1:0] flit_data;

  logic             credit_valid;
  logic [VCW-1:0]   credit_vch;

  modport slave (
    input  req_valid, req_dst_x, req_dst_y, req_vch, req_len,
    input  pl_valid, pl_data, credit_valid, credit_vch,
    output req_ready, pl_ready, flit_valid, flit_type, flit_vch, flit_data
  );

  modport master (
    output req_valid, req_dst_x, req_dst_y, req_vch, req_len,
    output pl_valid, pl_data, credit_valid, credit_vch,
    input  req_ready, pl_ready, flit_valid, flit_type, flit_vch, flit_data
  );
endinterface

// File: rtl/ni_inject.sv
// NI packetizer: header flit one cycle after request accept, then one payload flit per cycle.
// Backpressure comes only from per-VC credits; pl_ready drops while the packet's VC has none.
module ni_inject #(
  parameter int DATAW   = 32,
  parameter int XW      = 4,
  parameter int YW      = 4,
  parameter int NVCH    = 2,
  parameter int CREDITS = 4,
  parameter int LENW    = 4
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic [XW-1:0] my_xpos,
  input  logic [YW-1:0] my_ypos,
  ni_inject_if.slave    io,
  output logic          credit_err
);
  localparam int VCW = (NVCH > 1) ? $clog2(NVCH) : 1;
  localparam int CW  = $clog2(CREDITS + 1);
  localparam int HW  = 2 * XW + 2 * YW + LENW;

  localparam logic [1:0] FT_HEAD     = 2'b00;
  localparam logic [1:0] FT_BODY     = 2'b01;
  localparam logic [1:0] FT_TAIL     = 2'b10;
  localparam logic [1:0] FT_HEADTAIL = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY} state_t;

  state_t                   state_q;
  logic [VCW-1:0]           vch_q;
  logic [LENW-1:0]          rem_q;
  logic [DATAW-1:0]         hdr_q;
  logic [NVCH-1:0][CW-1:0]  credit_q, credit_d;
  logic                     err_q, err_d;
  logic                     fv_q;
  logic [1:0]               ft_q;
  logic [VCW-1:0]           fvch_q;
  logic [DATAW-1:0]         fd_q;

  logic                     has_credit;
  logic                     send;
  logic [HW-1:0]            hdr_fields;

  assign has_credit  = credit_q[vch_q] != '0;
  assign send        = has_credit && ((state_q == S_HEAD) || (state_q == S_BODY && io.pl_valid));
  assign hdr_fields  = {io.req_len, my_ypos, my_xpos, io.req_dst_y, io.req_dst_x};

  assign io.req_ready  = (state_q == S_IDLE);
  assign io.pl_ready   = (state_q == S_BODY) && has_credit;
  assign io.flit_valid = fv_q;
  assign io.flit_type  = ft_q;
  assign io.flit_vch   = fvch_q;
  assign io.flit_data  = fd_q;
  assign credit_err    = err_q;

  // A send and a return on the same VC cancel, so the counter is left alone.
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    for (int v = 0; v < NVCH; v++) begin
      if (io.credit_valid && io.credit_vch == VCW'(v) && !(send && vch_q == VCW'(v))) begin
        if (credit_q[v] == CW'(CREDITS)) err_d = 1'b1;
        else                             credit_d[v] = credit_q[v] + 1'b1;
      end else if (send && vch_q == VCW'(v) &&
                   !(io.credit_valid && io.credit_vch == VCW'(v))) begin
        credit_d[v] = credit_q[v] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q  <= S_IDLE;
      vch_q    <= '0;
      rem_q    <= '0;
      hdr_q    <= '0;
      credit_q <= {NVCH{CW'(CREDITS)}};
      err_q    <= 1'b0;
      fv_q     <= 1'b0;
      ft_q     <= 2'b00;
      fvch_q   <= '0;
      fd_q     <= '0;
    end else begin
      credit_q <= credit_d;
      err_q    <= err_d;
      fv_q     <= send;
      ft_q     <= 2'b00;
      fvch_q   <= '0;
      fd_q     <= '0;
      case (state_q)
        S_IDLE: begin
          if (io.req_valid) begin
            vch_q   <= io.req_vch;
            rem_q   <= io.req_len;
            hdr_q   <= DATAW'(hdr_fields);
            state_q <= S_HEAD;
          end
        end
        S_HEAD: begin
          if (has_credit) begin
            ft_q    <= (rem_q == '0) ? FT_HEADTAIL : FT_HEAD;
            fvch_q  <= vch_q;
            fd_q    <= hdr_q;
            state_q <= (rem_q == '0) ? S_IDLE : S_BODY;
          end
        end
        S_BODY: begin
          if (io.pl_valid && has_credit) begin
            ft_q   <= (rem_q == LENW'(1)) ? FT_TAIL : FT_BODY;
            fvch_q <= vch_q;
            fd_q   <= io.pl_data;
            rem_q  <= rem_q - 1'b1;
            if (rem_q == LENW'(1)) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ni_inject.sv
// Directed bench for ni_inject: per-cycle vector table plus stall and mid-packet reset sequences.
module tb_ni_inject;
  logic       clk = 1'b0;
  logic       rst_;
  logic [3:0] my_xpos, my_ypos;
  logic       credit_err;
  int         nchk = 0;
  int         npass = 0;

  ni_inject_if #(.DATAW(32), .XW(4), .YW(4), .NVCH(2), .LENW(4)) bus ();

  ni_inject #(.DATAW(32), .XW(4), .YW(4), .NVCH(2), .CREDITS(4), .LENW(4)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .my_xpos    (my_xpos),
    .my_ypos    (my_ypos),
    .io         (bus),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [3:0]  dx, dy;
    logic        vch;
    logic [3:0]  len;
    logic        pv;
    logic [31:0] pd;
    logic        cv, cvch;
    logic        fv;
    logic [1:0]  ft;
    logic        fvch;
    logic [31:0] fd;
    logic        rr, pr, err;
    int          c0, c1;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic rst, input logic rv, input logic [3:0] dx,
                              input logic [3:0] dy, input logic vch, input logic [3:0] len,
                              input logic pv, input logic [31:0] pd, input logic cv,
                              input logic cvch, input logic fv, input logic [1:0] ft,
                              input logic fvch, input logic [31:0] fd, input logic rr,
                              input logic pr, input logic err, input int c0, input int c1);
    vec_t r;
    r.rst = rst; r.rv = rv; r.dx = dx; r.dy = dy; r.vch = vch; r.len = len;
    r.pv = pv; r.pd = pd; r.cv = cv; r.cvch = cvch;
    r.fv = fv; r.ft = ft; r.fvch = fvch; r.fd = fd;
    r.rr = rr; r.pr = pr; r.err = err; r.c0 = c0; r.c1 = c1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    else             npass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst_ = 1'b0;
    bus.req_valid = 1'b0; bus.req_dst_x = '0; bus.req_dst_y = '0;
    bus.req_vch = '0; bus.req_len = '0;
    bus.pl_valid = 1'b0; bus.pl_data = '0;
    bus.credit_valid = 1'b0; bus.credit_vch = '0;
  endtask

  initial begin
    int nflit;
    logic [1:0] last_ft;
    my_xpos = 4'd1;
    my_ypos = 4'd1;
    idle_inputs();
    rst_ = 1'b1;

    //          rst rv dx dy vc ln pv pd            cv cvc | fv ft fvc fd            rr pr er c0 c1
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0,   0, 0, 0, 32'h0,        1, 0, 0, 4, 4);
    vecs[1]  = mk(0, 1, 3, 2, 1, 2, 0, 32'h0,        0, 0,   0, 0, 0, 32'h0,        0, 0, 0, 4, 4);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 1, 32'hA5A5A5A5, 0, 0,   1, 0, 1, 32'h00021123, 0, 1, 0, 4, 3);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 1, 32'hA5A5A5A5, 0, 0,   1, 1, 1, 32'hA5A5A5A5, 0, 1, 0, 4, 2);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 1, 32'h5A5A5A5A, 0, 0,   1, 2, 1, 32'h5A5A5A5A, 1, 0, 0, 4, 1);
    vecs[5]  = mk(0, 1, 1, 1, 0, 0, 0, 32'h0,        0, 0,   0, 0, 0, 32'h0,        0, 0, 0, 4, 1);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0,   1, 3, 0, 32'h00001111, 1, 0, 0, 3, 1);
    vecs[7]  = mk(0, 1, 2, 3, 1, 1, 0, 32'h0,        0, 0,   0, 0, 0, 32'h0,        0, 0, 0, 3, 1);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 1,   1, 0, 1, 32'h00011132, 0, 1, 0, 3, 1);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1, 32'h12345678, 1, 0,   1, 2, 1, 32'h12345678, 1, 0, 0, 4, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 1,   0, 0, 0, 32'h0,        1, 0, 0, 4, 1);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 1,   0, 0, 0, 32'h0,        1, 0, 0, 4, 2);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 1,   0, 0, 0, 32'h0,        1, 0, 0, 4, 3);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 1,   0, 0, 0, 32'h0,        1, 0, 0, 4, 4);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 0,   0, 0, 0, 32'h0,        1, 0, 1, 4, 4);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0,   0, 0, 0, 32'h0,        1, 0, 1, 4, 4);
    vecs[16] = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0,   0, 0, 0, 32'h0,        1, 0, 0, 4, 4);

    for (int i = 0; i < 17; i++) begin
      rst_ = vecs[i].rst;
      bus.req_valid = vecs[i].rv;   bus.req_dst_x = vecs[i].dx; bus.req_dst_y = vecs[i].dy;
      bus.req_vch = vecs[i].vch;    bus.req_len = vecs[i].len;
      bus.pl_valid = vecs[i].pv;    bus.pl_data = vecs[i].pd;
      bus.credit_valid = vecs[i].cv; bus.credit_vch = vecs[i].cvch;
      step();
      chk($sformatf("v%0d.flit_valid", i), 32'(bus.flit_valid), 32'(vecs[i].fv));
      chk($sformatf("v%0d.flit_type", i),  32'(bus.flit_type),  32'(vecs[i].ft));
      chk($sformatf("v%0d.flit_vch", i),   32'(bus.flit_vch),   32'(vecs[i].fvch));
      chk($sformatf("v%0d.flit_data", i),  bus.flit_data,       vecs[i].fd);
      chk($sformatf("v%0d.req_ready", i),  32'(bus.req_ready),  32'(vecs[i].rr));
      chk($sformatf("v%0d.pl_ready", i),   32'(bus.pl_ready),   32'(vecs[i].pr));
      chk($sformatf("v%0d.credit_err", i), 32'(credit_err),     32'(vecs[i].err));
      chk($sformatf("v%0d.credit0", i),    32'(dut.credit_q[0]), vecs[i].c0);
      chk($sformatf("v%0d.credit1", i),    32'(dut.credit_q[1]), vecs[i].c1);
    end

    // Credit exhaustion: len=6 on VC1 with no returns stalls after 4 flits.
    idle_inputs();
    bus.req_valid = 1'b1; bus.req_dst_x = 4'd3; bus.req_dst_y = 4'd2;
    bus.req_vch = 1'b1; bus.req_len = 4'd6;
    step();
    bus.req_valid = 1'b0;
    bus.pl_valid = 1'b1;
    bus.pl_data = 32'h100;
    nflit = 0;
    last_ft = 2'b00;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus.flit_valid) begin
        nflit++;
        last_ft = bus.flit_type;
        bus.pl_data = bus.pl_data + 1;
      end
    end
    chk("stall.flits", 32'(nflit), 32'd4);
    chk("stall.pl_ready", 32'(bus.pl_ready), 32'd0);
    chk("stall.credit1", 32'(dut.credit_q[1]), 32'd0);
    chk("stall.req_ready", 32'(bus.req_ready), 32'd0);
    bus.credit_valid = 1'b1; bus.credit_vch = 1'b1;
    step();
    bus.credit_valid = 1'b0;
    chk("stall.pl_ready_after_credit", 32'(bus.pl_ready), 32'd1);
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.flit_valid) begin
        nflit++;
        last_ft = bus.flit_type;
      end
    end
    chk("stall.flits_after_credit", 32'(nflit), 32'd5);
    chk("stall.last_type", 32'(last_ft), 32'd1);
    chk("stall.pl_ready_again", 32'(bus.pl_ready), 32'd0);
    chk("stall.credit1_again", 32'(dut.credit_q[1]), 32'd0);

    // Reset mid-packet abandons it: no tail afterwards.
    idle_inputs();
    rst_ = 1'b1;
    step();
    rst_ = 1'b0;
    bus.req_valid = 1'b1; bus.req_dst_x = 4'd2; bus.req_dst_y = 4'd2;
    bus.req_vch = 1'b0; bus.req_len = 4'd3;
    step();
    bus.req_valid = 1'b0;
    bus.pl_valid = 1'b1;
    bus.pl_data = 32'hCAFE0001;
    step();
    chk("rstmid.head_type", 32'(bus.flit_type), 32'd0);
    step();
    chk("rstmid.body_type", 32'(bus.flit_type), 32'd1);
    chk("rstmid.body_data", bus.flit_data, 32'hCAFE0001);
    rst_ = 1'b1;
    step();
    rst_ = 1'b0;
    chk("rstmid.flit_valid", 32'(bus.flit_valid), 32'd0);
    chk("rstmid.req_ready", 32'(bus.req_ready), 32'd1);
    chk("rstmid.pl_ready", 32'(bus.pl_ready), 32'd0);
    chk("rstmid.credit0", 32'(dut.credit_q[0]), 32'd4);
    chk("rstmid.credit1", 32'(dut.credit_q[1]), 32'd4);
    nflit = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.flit_valid) nflit++;
    end
    chk("rstmid.no_tail", 32'(nflit), 32'd0);
    chk("rstmid.credit_err", 32'(credit_err), 32'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
